// File: rtl/bd_emu_pkg.sv
// Shared types and helpers for the Braindrop pin-interface loopback emulator.
// Pin word widths live here so FPGA-side and emulator-side code agree on them.
package bd_emu_pkg;

    localparam int NUM_BITS_PIN2CORE = 21;
    localparam int NUM_BITS_CORE2PIN = 34;

    // Widest word adapt_word handles; both pin widths must fit inside it.
    localparam int ADAPT_MAX_W = 64;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Keeps the low min(in_w, out_w) bits: zero-extends a narrow word, truncates a wide one.
    function automatic logic [ADAPT_MAX_W-1:0] adapt_word(
        input logic [ADAPT_MAX_W-1:0] word,
        input int                     in_w,
        input int                     out_w
    );
        logic [ADAPT_MAX_W-1:0] res;
        int                     keep;
        keep = (in_w < out_w) ? in_w : out_w;
        res  = '0;
        for (int i = 0; i < ADAPT_MAX_W; i++) begin
            if (i < keep) res[i] = word[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/bd_emu_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a word pushed at edge t is visible on head_dat just after t.
// Backpressure: pushes while full and pops while empty are ignored.
module bd_emu_fifo
    import bd_emu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_vld,
    input  logic [WIDTH-1:0]        push_dat,
    input  logic                    pop_rdy,
    output logic [WIDTH-1:0]        head_dat,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push_vld && !full;
        do_pop   = pop_rdy && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        head_dat = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/bd_loopback_emulator.sv
// Chip-side stand-in for Braindrop: buffers every downstream pin word and returns it upstream width-adapted.
// Latency: a word accepted at edge t is on out_data just after t and can be popped at t+1.
// Backpressure: in_ready drops when the buffer is full or on the periodic stall cycle; out_data holds while out_ready is low.
module bd_loopback_emulator
    import bd_emu_pkg::*;
#(
    parameter int NUM_BITS_IN  = NUM_BITS_PIN2CORE,
    parameter int NUM_BITS_OUT = NUM_BITS_CORE2PIN,
    parameter int DEPTH        = 16,
    parameter int STALL_PERIOD = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [NUM_BITS_IN-1:0]  in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [NUM_BITS_OUT-1:0] out_data,
    input  logic                    out_ready,
    output logic [cnt_w(DEPTH)-1:0] fifo_count,
    output logic [15:0]             in_words,
    output logic [15:0]             out_words
);

    localparam int SCW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SCW-1:0] STALL_LAST = SCW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

    logic [SCW-1:0]         stall_cnt_q, stall_cnt_d;
    logic [15:0]            in_words_q, in_words_d;
    logic [15:0]            out_words_q, out_words_d;
    logic                   stall;
    logic                   push, pop;
    logic                   fifo_full, fifo_empty;
    logic [NUM_BITS_IN-1:0] head_dat;

    bd_emu_fifo #(
        .WIDTH (NUM_BITS_IN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push_vld (push),
        .push_dat (in_data),
        .pop_rdy  (pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Gating with reset keeps in_ready low while reset is held and high the moment it releases.
    always_comb begin
        stall       = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);
        in_ready    = reset && !fifo_full && !stall;
        out_valid   = !fifo_empty;
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        stall_cnt_d = (stall || STALL_PERIOD == 0) ? '0 : stall_cnt_q + SCW'(1);
        in_words_d  = in_words_q + 16'(push);
        out_words_d = out_words_q + 16'(pop);
        out_data    = fifo_empty ? '0
                    : NUM_BITS_OUT'(adapt_word(ADAPT_MAX_W'(head_dat), NUM_BITS_IN, NUM_BITS_OUT));
        in_words    = in_words_q;
        out_words   = out_words_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            in_words_q  <= '0;
            out_words_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            in_words_q  <= in_words_d;
            out_words_q <= out_words_d;
        end
    end

endmodule

// File: tb/tb_bd_loopback_emulator.sv
// Two emulators share one stimulus: A widens 21->34 bits without stalls, B truncates 34->21 bits with a 4-cycle stall.
module tb_bd_loopback_emulator;

    localparam int A_IN = 21, A_OUT = 34, A_D = 16, A_P = 0;
    localparam int B_IN = 34, B_OUT = 21, B_D = 8,  B_P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, out_ready;
    logic [33:0] in_data;

    logic        rdy_a, vld_a, rdy_b, vld_b;
    logic [33:0] dat_a;
    logic [20:0] dat_b;
    logic [4:0]  cnt_a;
    logic [3:0]  cnt_b;
    logic [15:0] inw_a, outw_a, inw_b, outw_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bd_loopback_emulator #(
        .NUM_BITS_IN (A_IN), .NUM_BITS_OUT (A_OUT), .DEPTH (A_D), .STALL_PERIOD (A_P)
    ) dut_a (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_data (in_data[20:0]), .in_ready (rdy_a),
        .out_valid (vld_a), .out_data (dat_a), .out_ready (out_ready),
        .fifo_count (cnt_a), .in_words (inw_a), .out_words (outw_a)
    );

    bd_loopback_emulator #(
        .NUM_BITS_IN (B_IN), .NUM_BITS_OUT (B_OUT), .DEPTH (B_D), .STALL_PERIOD (B_P)
    ) dut_b (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_data (in_data), .in_ready (rdy_b),
        .out_valid (vld_b), .out_data (dat_b), .out_ready (out_ready),
        .fifo_count (cnt_b), .in_words (inw_b), .out_words (outw_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int mcyc = 0;
    int mi_a = 0, mo_a = 0, mi_b = 0, mo_b = 0;

    function automatic bit stall_at(int cyc, int p);
        return (p != 0) && ((cyc % p) == p - 1);
    endfunction

    function automatic logic [63:0] low_bits(logic [63:0] w, int n);
        return w & ((64'd1 << n) - 64'd1);
    endfunction

    function automatic bit m_rdy(int depth, int p, int size);
        return reset && (size < depth) && !stall_at(mcyc, p);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            qa.delete();
            qb.delete();
            mcyc = 0;
            mi_a = 0; mo_a = 0; mi_b = 0; mo_b = 0;
        end else begin
            bit pa, oa, pb, ob;
            pa = in_valid && m_rdy(A_D, A_P, qa.size());
            oa = out_ready && (qa.size() != 0);
            pb = in_valid && m_rdy(B_D, B_P, qb.size());
            ob = out_ready && (qb.size() != 0);
            if (oa) begin void'(qa.pop_front()); mo_a++; end
            if (ob) begin void'(qb.pop_front()); mo_b++; end
            if (pa) begin qa.push_back(low_bits(64'(in_data), (A_IN < A_OUT) ? A_IN : A_OUT)); mi_a++; end
            if (pb) begin qb.push_back(low_bits(64'(in_data), (B_IN < B_OUT) ? B_IN : B_OUT)); mi_b++; end
            mcyc++;
        end
    end

    always @(negedge clk) begin
        check("a_rdy",  64'(rdy_a),  64'(m_rdy(A_D, A_P, qa.size())));
        check("a_vld",  64'(vld_a),  64'(qa.size() != 0));
        check("a_dat",  64'(dat_a),  (qa.size() != 0) ? qa[0] : 64'd0);
        check("a_cnt",  64'(cnt_a),  64'(qa.size()));
        check("a_inw",  64'(inw_a),  64'(mi_a % 65536));
        check("a_outw", 64'(outw_a), 64'(mo_a % 65536));
        check("b_rdy",  64'(rdy_b),  64'(m_rdy(B_D, B_P, qb.size())));
        check("b_vld",  64'(vld_b),  64'(qb.size() != 0));
        check("b_dat",  64'(dat_b),  (qb.size() != 0) ? qb[0] : 64'd0);
        check("b_cnt",  64'(cnt_b),  64'(qb.size()));
        check("b_inw",  64'(inw_b),  64'(mi_b % 65536));
        check("b_outw", 64'(outw_b), 64'(mo_b % 65536));
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        int n;
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b0;

        repeat (3) begin
            tick();
            check("rst_rdy_a", 64'(rdy_a), 64'd0);
            check("rst_vld_a", 64'(vld_a), 64'd0);
            check("rst_inw_a", 64'(inw_a), 64'd0);
            check("rst_cnt_b", 64'(cnt_b), 64'd0);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel_rdy_a", 64'(rdy_a), 64'd1);
        check("rel_rdy_b", 64'(rdy_b), 64'd1);

        in_valid = 1'b1;
        in_data  = 34'h1ABCDE;
        tick();
        in_valid = 1'b0;
        check("one_vld_a", 64'(vld_a), 64'd1);
        check("one_dat_a", 64'(dat_a), 64'h0001ABCDE);
        check("one_dat_b", 64'(dat_b), 64'h1ABCDE);
        check("one_inw_a", 64'(inw_a), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("one_outw_a", 64'(outw_a), 64'd1);
        check("one_empty_a", 64'(vld_a), 64'd0);

        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 34'(i + 'h100);
            tick();
        end
        in_valid = 1'b0;
        check("fill_cnt_a", 64'(cnt_a), 64'd16);
        check("fill_rdy_a", 64'(rdy_a), 64'd0);
        out_ready = 1'b1;
        tick();
        check("fill_rdy_back_a", 64'(rdy_a), 64'd1);
        check("fill_head2_a", 64'(dat_a), 64'h101);
        check("fill_cnt15_a", 64'(cnt_a), 64'd15);
        repeat (20) tick();
        out_ready = 1'b0;
        check("fill_drained_a", 64'(vld_a), 64'd0);

        start = mi_a;
        n = 0;
        while ((mi_a - start) < 1000 && n < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 34'({$urandom(), $urandom()});
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check("bp_inw_a",  64'(inw_a),  64'd1017);
        check("bp_outw_a", 64'(outw_a), 64'd1017);
        check("bp_empty_a", 64'(vld_a), 64'd0);

        reset = 1'b0;
        repeat (3) tick();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        reset     = 1'b1;
        #1;
        for (int k = 0; k < 40; k++) begin
            check("stall_rdy_b", 64'(rdy_b), 64'((k % 4) != 3));
            tick();
        end
        in_valid = 1'b0;
        check("stall_inw_b", 64'(inw_b), 64'd30);
        check("stall_inw_a", 64'(inw_a), 64'd40);

        repeat (3) tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 34'h3_FFFF_FFFF;
        n = 0;
        while (qb.size() < 5 && n < 40) begin
            tick();
            if (qb.size() >= 1) in_data = 34'(n + 'h55);
            n++;
        end
        in_valid = 1'b0;
        check("trunc_dat_b", 64'(dat_b), 64'h1FFFFF);
        check("trunc_dat_a", 64'(dat_a), 64'h1FFFFF);
        check("trunc_cnt_b", 64'(cnt_b), 64'd5);
        reset = 1'b0;
        #1;
        check("arst_cnt_b", 64'(cnt_b), 64'd0);
        check("arst_vld_b", 64'(vld_b), 64'd0);
        check("arst_vld_a", 64'(vld_a), 64'd0);
        check("arst_cnt_a", 64'(cnt_a), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
